// File: rtl/mps_pkg.sv
// Shared definitions for the MPS precharge/contactor sequencer: state encoding,
// first-fault codes and contactor bit positions.
package mps_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PRECHG     = 3'd1,
    ST_MAIN_CLOSE = 3'd2,
    ST_READY      = 3'd3,
    ST_DISCHG     = 3'd4,
    ST_FAULT      = 3'd5
  } state_e;

  localparam logic [3:0] FC_NONE    = 4'd0;
  localparam logic [3:0] FC_PRE_TO  = 4'd1;
  localparam logic [3:0] FC_MC_TO   = 4'd2;
  localparam logic [3:0] FC_MC_LOST = 4'd3;
  localparam logic [3:0] FC_DIS_TO  = 4'd4;
  localparam logic [3:0] FC_INTL    = 4'd5;

  localparam int MC_PRE  = 0;
  localparam int MC_MAIN = 1;
  localparam int MC_DIS  = 2;

  // Contactor drive pattern {dis, main, pre} for each state.
  function automatic logic [2:0] mc_decode(state_e s);
    logic [2:0] mc;
    mc = 3'b000;
    case (s)
      ST_PRECHG:     mc[MC_PRE] = 1'b1;
      ST_MAIN_CLOSE: begin
        mc[MC_PRE]  = 1'b1;
        mc[MC_MAIN] = 1'b1;
      end
      ST_READY:      mc[MC_MAIN] = 1'b1;
      ST_DISCHG,
      ST_FAULT:      mc[MC_DIS] = 1'b1;
      default:       mc = 3'b000;
    endcase
    return mc;
  endfunction

endpackage

// File: rtl/mps_precharge_seq_if.sv
// Request/threshold/feedback inputs and contactor/status outputs of the
// precharge sequencer, grouped as one bundle.
interface mps_precharge_seq_if #(
  parameter int P_DW = 32,
  parameter int P_TW = 32
);
  logic            i_on_req;
  logic            i_off_req;
  logic            i_intl;
  logic            i_fault_clr;
  logic [P_DW-1:0] i_dc_v;
  logic [2:0]      i_mc_fb;
  logic [P_DW-1:0] i_pre_th;
  logic [P_DW-1:0] i_dis_th;
  logic [P_TW-1:0] i_pre_to;
  logic [P_TW-1:0] i_mc_to;
  logic [P_TW-1:0] i_dis_to;
  logic [2:0]      o_mc;
  logic            o_ready;
  logic            o_fault;
  logic [3:0]      o_fail_code;
  logic [2:0]      o_state;

  modport master (
    output i_on_req, i_off_req, i_intl, i_fault_clr, i_dc_v, i_mc_fb,
           i_pre_th, i_dis_th, i_pre_to, i_mc_to, i_dis_to,
    input  o_mc, o_ready, o_fault, o_fail_code, o_state
  );

  modport slave (
    input  i_on_req, i_off_req, i_intl, i_fault_clr, i_dc_v, i_mc_fb,
           i_pre_th, i_dis_th, i_pre_to, i_mc_to, i_dis_to,
    output o_mc, o_ready, o_fault, o_fail_code, o_state
  );
endinterface

// File: rtl/mps_seq_timer.sv
// Per-state timer: cleared on state entry, saturating up-count, and a hit flag
// when the count equals a non-zero timeout setting.
module mps_seq_timer #(
  parameter int P_TW = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_clr,
  input  logic [P_TW-1:0] i_cfg,
  output logic            o_hit
);

  logic [P_TW-1:0] cnt_q;
  logic [P_TW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero setting disables the timeout entirely.
  assign o_hit = (i_cfg != '0) && (cnt_q == i_cfg);

endmodule

// File: rtl/mps_precharge_seq.sv
// DC-link precharge and contactor sequencer: steps precharge/main/discharge
// contactors in order, checks feedback and timeouts, latches a first-fault code.
module mps_precharge_seq
  import mps_pkg::*;
#(
  parameter int P_DW = 32,
  parameter int P_TW = 32
) (
  input logic                 i_clk,
  input logic                 i_rst,
  mps_precharge_seq_if.slave  bus
);

  state_e          state_q, state_d;
  logic [3:0]      fail_q, fail_d;
  logic [P_DW-1:0] dc_v;
  logic [P_TW-1:0] tmr_cfg;
  logic            tmr_hit;
  logic            pre_ok;
  logic            dis_ok;

  logic [2:0] mc_q, mc_d;
  logic       ready_q, ready_d;
  logic       fault_q, fault_d;
  logic [3:0] code_q, code_d;
  logic [2:0] st_q, st_d;

  assign dc_v   = bus.i_dc_v;
  assign pre_ok = (dc_v >= bus.i_pre_th);
  assign dis_ok = (dc_v <  bus.i_dis_th);

  // One timer shared by all timed states; its limit follows the current state.
  always_comb begin
    tmr_cfg = '0;
    case (state_q)
      ST_PRECHG:     tmr_cfg = bus.i_pre_to;
      ST_MAIN_CLOSE: tmr_cfg = bus.i_mc_to;
      ST_DISCHG:     tmr_cfg = bus.i_dis_to;
      default:       tmr_cfg = '0;
    endcase
  end

  mps_seq_timer #(.P_TW(P_TW)) u_timer (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (state_d != state_q),
    .i_cfg (tmr_cfg),
    .o_hit (tmr_hit)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      fail_q  <= FC_NONE;
    end else begin
      state_q <= state_d;
      fail_q  <= fail_d;
    end
  end

  // Branch order encodes priority: interlock, then timeout/feedback loss, then off, then progress.
  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_on_req && !bus.i_intl && !bus.i_off_req) state_d = ST_PRECHG;
      end
      ST_PRECHG: begin
        if (bus.i_intl) begin
          state_d = ST_FAULT; fail_d = FC_INTL;
        end else if (tmr_hit) begin
          state_d = ST_FAULT; fail_d = FC_PRE_TO;
        end else if (bus.i_off_req) begin
          state_d = ST_DISCHG;
        end else if (pre_ok) begin
          state_d = ST_MAIN_CLOSE;
        end
      end
      ST_MAIN_CLOSE: begin
        if (bus.i_intl) begin
          state_d = ST_FAULT; fail_d = FC_INTL;
        end else if (tmr_hit) begin
          state_d = ST_FAULT; fail_d = FC_MC_TO;
        end else if (bus.i_off_req) begin
          state_d = ST_DISCHG;
        end else if (bus.i_mc_fb[MC_MAIN]) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (bus.i_intl) begin
          state_d = ST_FAULT; fail_d = FC_INTL;
        end else if (!bus.i_mc_fb[MC_MAIN]) begin
          state_d = ST_FAULT; fail_d = FC_MC_LOST;
        end else if (bus.i_off_req) begin
          state_d = ST_DISCHG;
        end
      end
      ST_DISCHG: begin
        if (bus.i_intl) begin
          state_d = ST_FAULT; fail_d = FC_INTL;
        end else if (tmr_hit) begin
          state_d = ST_FAULT; fail_d = FC_DIS_TO;
        end else if (dis_ok) begin
          state_d = ST_IDLE;
        end
      end
      ST_FAULT: begin
        if (bus.i_fault_clr && !bus.i_intl && dis_ok) begin
          state_d = ST_IDLE; fail_d = FC_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE; fail_d = FC_NONE;
      end
    endcase
  end

  always_comb begin
    mc_d    = mc_decode(state_q);
    ready_d = (state_q == ST_READY);
    fault_d = (state_q == ST_FAULT);
    code_d  = fail_q;
    st_d    = state_q;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      mc_q    <= 3'b000;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
      st_q    <= ST_IDLE;
    end else begin
      mc_q    <= mc_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      st_q    <= st_d;
    end
  end

  assign bus.o_mc        = mc_q;
  assign bus.o_ready     = ready_q;
  assign bus.o_fault     = fault_q;
  assign bus.o_fail_code = code_q;
  assign bus.o_state     = st_q;

endmodule

// File: tb/tb_mps_precharge_seq.sv
// Table-driven scoreboard bench for the precharge sequencer plus hand-written
// timeout, long-hold and asynchronous-reset sequences.
module tb_mps_precharge_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mps_precharge_seq_if #(.P_DW(32), .P_TW(32)) bus ();

  mps_precharge_seq #(.P_DW(32), .P_TW(32)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        on;
    logic        off;
    logic        intl;
    logic        clr;
    logic [31:0] dc;
    logic [2:0]  fb;
    logic [2:0]  st;
    logic [3:0]  code;
  } vec_t;

  typedef struct {
    int         due;
    int         idx;
    logic [2:0] st;
    logic [3:0] code;
  } exp_t;

  localparam int NV = 35;
  vec_t tbl [NV];
  exp_t sb [$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [2:0] spec_mc(logic [2:0] s);
    case (s)
      3'd1:    return 3'b001;
      3'd2:    return 3'b011;
      3'd3:    return 3'b010;
      3'd4:    return 3'b100;
      3'd5:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic check_due();
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      if (e.due == cyc) begin
        $display("vec %0d: state=%0d mc=%b ready=%b fault=%b code=%0d (exp state=%0d code=%0d)",
                 e.idx, bus.o_state, bus.o_mc, bus.o_ready, bus.o_fault, bus.o_fail_code,
                 e.st, e.code);
        chk($sformatf("vec%0d state", e.idx), {29'd0, bus.o_state}, {29'd0, e.st});
        chk($sformatf("vec%0d mc", e.idx), {29'd0, bus.o_mc}, {29'd0, spec_mc(e.st)});
        chk($sformatf("vec%0d ready", e.idx), {31'd0, bus.o_ready}, {31'd0, e.st == 3'd3});
        chk($sformatf("vec%0d fault", e.idx), {31'd0, bus.o_fault}, {31'd0, e.st == 3'd5});
        chk($sformatf("vec%0d code", e.idx), {28'd0, bus.o_fail_code}, {28'd0, e.code});
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_due();
  endtask

  task automatic drive(input logic on, input logic off, input logic intl, input logic clr,
                       input logic [31:0] dc, input logic [2:0] fb);
    bus.i_on_req    = on;
    bus.i_off_req   = off;
    bus.i_intl      = intl;
    bus.i_fault_clr = clr;
    bus.i_dc_v      = dc;
    bus.i_mc_fb     = fb;
  endtask

  task automatic step_vec(input int i);
    exp_t e;
    drive(tbl[i].on, tbl[i].off, tbl[i].intl, tbl[i].clr, tbl[i].dc, tbl[i].fb);
    e.due  = cyc + 2;
    e.idx  = i;
    e.st   = tbl[i].st;
    e.code = tbl[i].code;
    sb.push_back(e);
    tick();
  endtask

  task automatic set_v(input int i, input logic on, input logic off, input logic intl,
                       input logic clr, input logic [31:0] dc, input logic [2:0] fb,
                       input logic [2:0] st, input logic [3:0] code);
    tbl[i].on = on;  tbl[i].off = off; tbl[i].intl = intl; tbl[i].clr = clr;
    tbl[i].dc = dc;  tbl[i].fb = fb;   tbl[i].st = st;     tbl[i].code = code;
  endtask

  task automatic wait_state(input string name, input logic [2:0] s, input int max, output int n);
    n = 0;
    while (bus.o_state !== s && n < max) begin
      tick();
      n++;
    end
    chk(name, {29'd0, bus.o_state}, {29'd0, s});
  endtask

  int n, n2, bad;

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 3'b000);
    bus.i_pre_th = 32'd1000;
    bus.i_dis_th = 32'd50;
    bus.i_pre_to = 32'd0;
    bus.i_mc_to  = 32'd0;
    bus.i_dis_to = 32'd0;

    //      idx on off intl clr dc     fb      st  code
    set_v( 0, 0, 0, 0, 0, 32'd0,    3'b000, 3'd0, 4'd0);
    set_v( 1, 0, 1, 0, 0, 32'd0,    3'b000, 3'd0, 4'd0);
    set_v( 2, 1, 0, 1, 0, 32'd0,    3'b000, 3'd0, 4'd0);
    set_v( 3, 1, 1, 0, 0, 32'd0,    3'b000, 3'd0, 4'd0);
    set_v( 4, 1, 0, 0, 0, 32'd0,    3'b000, 3'd1, 4'd0);
    set_v( 5, 1, 0, 0, 0, 32'd500,  3'b000, 3'd1, 4'd0);
    set_v( 6, 0, 0, 0, 0, 32'd999,  3'b000, 3'd1, 4'd0);
    set_v( 7, 0, 0, 0, 0, 32'd1000, 3'b000, 3'd2, 4'd0);
    set_v( 8, 0, 0, 0, 0, 32'd1000, 3'b000, 3'd2, 4'd0);
    set_v( 9, 0, 0, 0, 0, 32'd1000, 3'b000, 3'd2, 4'd0);
    set_v(10, 0, 0, 0, 0, 32'd1000, 3'b000, 3'd2, 4'd0);
    set_v(11, 0, 0, 0, 0, 32'd1000, 3'b000, 3'd2, 4'd0);
    set_v(12, 0, 0, 0, 0, 32'd1000, 3'b010, 3'd3, 4'd0);
    set_v(13, 1, 0, 0, 0, 32'd1000, 3'b010, 3'd3, 4'd0);
    set_v(14, 0, 1, 0, 0, 32'd1000, 3'b010, 3'd4, 4'd0);
    set_v(15, 0, 0, 0, 0, 32'd60,   3'b000, 3'd4, 4'd0);
    set_v(16, 0, 0, 0, 0, 32'd50,   3'b000, 3'd4, 4'd0);
    set_v(17, 0, 0, 0, 0, 32'd49,   3'b000, 3'd0, 4'd0);
    set_v(18, 1, 0, 0, 0, 32'd0,    3'b000, 3'd1, 4'd0);
    set_v(19, 0, 0, 0, 0, 32'd1000, 3'b000, 3'd2, 4'd0);
    set_v(20, 0, 0, 0, 0, 32'd1000, 3'b010, 3'd3, 4'd0);
    set_v(21, 0, 1, 0, 0, 32'd1000, 3'b000, 3'd5, 4'd3);
    set_v(22, 0, 0, 1, 0, 32'd1000, 3'b000, 3'd5, 4'd3);
    set_v(23, 0, 0, 0, 1, 32'd1000, 3'b000, 3'd5, 4'd3);
    set_v(24, 0, 0, 0, 1, 32'd10,   3'b000, 3'd0, 4'd0);
    set_v(25, 1, 0, 0, 0, 32'd0,    3'b000, 3'd1, 4'd0);
    set_v(26, 0, 0, 0, 0, 32'd1000, 3'b000, 3'd2, 4'd0);
    set_v(27, 0, 0, 0, 0, 32'd1000, 3'b010, 3'd3, 4'd0);
    set_v(28, 0, 1, 1, 0, 32'd1000, 3'b010, 3'd5, 4'd5);
    set_v(29, 0, 0, 1, 1, 32'd10,   3'b000, 3'd5, 4'd5);
    set_v(30, 0, 0, 0, 0, 32'd10,   3'b000, 3'd5, 4'd5);
    set_v(31, 0, 0, 0, 1, 32'd10,   3'b000, 3'd0, 4'd0);
    set_v(32, 1, 0, 0, 0, 32'd0,    3'b000, 3'd1, 4'd0);
    set_v(33, 0, 0, 1, 0, 32'd0,    3'b000, 3'd5, 4'd5);
    set_v(34, 0, 0, 0, 1, 32'd0,    3'b000, 3'd0, 4'd0);

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset mc",    {29'd0, bus.o_mc}, 32'd0);
    chk("reset state", {29'd0, bus.o_state}, 32'd0);
    chk("reset ready", {31'd0, bus.o_ready}, 32'd0);
    chk("reset fault", {31'd0, bus.o_fault}, 32'd0);
    chk("reset code",  {28'd0, bus.o_fail_code}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) step_vec(i);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 3'b000);
    tick();
    tick();
    chk("scoreboard drained", sb.size(), 32'd0);

    // Precharge timeout of 100 cycles
    bus.i_pre_to = 32'd100;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 3'b000);
    wait_state("pre_to enter PRECHG", 3'd1, 10, n);
    bus.i_on_req = 1'b0;
    wait_state("pre_to enter FAULT", 3'd5, 300, n2);
    $display("pre_to: FAULT after %0d cycles, code=%0d mc=%b", n2, bus.o_fail_code, bus.o_mc);
    chk("pre_to cycles", n2, 32'd101);
    chk("pre_to code",  {28'd0, bus.o_fail_code}, 32'd1);
    chk("pre_to mc",    {29'd0, bus.o_mc}, 32'b100);
    chk("pre_to fault", {31'd0, bus.o_fault}, 32'd1);
    bus.i_fault_clr = 1'b1;
    tick();
    bus.i_fault_clr = 1'b0;
    tick();
    chk("pre_to clear state", {29'd0, bus.o_state}, 32'd0);
    chk("pre_to clear code",  {28'd0, bus.o_fail_code}, 32'd0);
    bus.i_pre_to = 32'd0;

    // Main-contactor feedback timeout of 10 cycles
    bus.i_mc_to = 32'd10;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd1000, 3'b000);
    wait_state("mc_to enter MAIN_CLOSE", 3'd2, 10, n);
    bus.i_on_req = 1'b0;
    wait_state("mc_to enter FAULT", 3'd5, 100, n2);
    $display("mc_to: FAULT after %0d cycles, code=%0d", n2, bus.o_fail_code);
    chk("mc_to cycles", n2, 32'd11);
    chk("mc_to code", {28'd0, bus.o_fail_code}, 32'd2);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 3'b000);
    tick();
    bus.i_fault_clr = 1'b0;
    wait_state("mc_to cleared", 3'd0, 5, n);
    bus.i_mc_to = 32'd0;

    // Discharge with timeout disabled and DC link stuck above threshold
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd1000, 3'b010);
    wait_state("hold enter READY", 3'd3, 20, n);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'd500, 3'b010);
    wait_state("hold enter DISCHG", 3'd4, 10, n);
    bus.i_off_req = 1'b0;
    bad = 0;
    for (int k = 0; k < 30000; k++) begin
      tick();
      if (bus.o_state !== 3'd4) bad++;
    end
    $display("hold: %0d cycles outside DISCHG, state=%0d mc=%b", bad, bus.o_state, bus.o_mc);
    chk("hold cycles outside DISCHG", bad, 32'd0);
    chk("hold mc", {29'd0, bus.o_mc}, 32'b100);
    bus.i_dc_v = 32'd0;
    wait_state("hold discharged", 3'd0, 10, n);

    // Asynchronous reset in the middle of precharge
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 3'b000);
    wait_state("async enter PRECHG", 3'd1, 10, n);
    bus.i_on_req = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    $display("async reset: mc=%b state=%0d ready=%b fault=%b code=%0d",
             bus.o_mc, bus.o_state, bus.o_ready, bus.o_fault, bus.o_fail_code);
    chk("async mc",    {29'd0, bus.o_mc}, 32'd0);
    chk("async state", {29'd0, bus.o_state}, 32'd0);
    chk("async ready", {31'd0, bus.o_ready}, 32'd0);
    chk("async fault", {31'd0, bus.o_fault}, 32'd0);
    chk("async code",  {28'd0, bus.o_fail_code}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk("after reset state", {29'd0, bus.o_state}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
